scale_coord_gen: RTL and testbench
==================================

# scale_coord_gen

Downstream consumer of the zoom-ratio lookup table in the HDMI 640x480 scaler path. It drives the table's address with the requested zoom level and latches the returned 0.16 step ratio, equal to 480/(480+k), once per frame. It then walks every output pixel in raster order, producing a fixed-point source coordinate (integer plus fraction) centred on the frame. The coordinate stream feeds the bilinear fetch/interpolation stage through a valid/ready handshake.

## Interface
- H_OUT, 640, output pixels per line (even)
- V_OUT, 480, output lines per frame (even)
- FRAC_W, 8, fraction bits exported per axis
- clk  in  1  pixel clock; every register uses rising edge
- rst  in  1  reset: synchronous, active-high
- zoom_level  in  10  requested LUT index k; 0 = unity, 1..240 = magnify
- frame_start  in  1  single-cycle pulse requesting a new frame walk
- lut_raddr  out  10  address to the ratio LUT (registered)
- lut_data  in  16  LUT data, combinational from lut_raddr
- busy  out  1  high from the cycle after an accepted frame_start until the last coordinate is accepted
- coord_valid  out  1  coordinate outputs valid
- coord_ready  in  1  downstream accepts when valid && ready
- sx_int, sy_int  out  10  integer source coordinate
- sx_next, sy_next  out  10  min(int+1, H_OUT-1) / min(int+1, V_OUT-1)
- sx_frac, sy_frac  out  FRAC_W  accumulator bits [15:16-FRAC_W]
- eol  out  1  coordinate is the last of its line
- eof  out  1  coordinate is the last of the frame

## Operation
- FSM has four states: IDLE, LATCH, CALC and RUN.
- **IDLE:** on frame_start, register zoom_level into lut_raddr and go to LATCH.
- **LATCH:** step S (17 bit) = 0x10000 when lut_raddr==0, lut_data when lut_raddr is 1..240, and 0x10000 when lut_raddr > 240. Register S and go to CALC.
- **CALC:** compute the centring offsets off_x = (H_OUT/2)*(0x10000-S) and off_y = (V_OUT/2)*(0x10000-S), each 26 bits (10.16). Load x_acc=off_x, y_acc=off_y, x_cnt=0, y_cnt=0 and go to RUN.
- **RUN:** coord_valid=1 and the outputs are driven from the accumulators. On each handshake:
  - not end of line: x_acc+=S, x_cnt++;
  - end of line (x_cnt==H_OUT-1): x_acc=off_x, x_cnt=0, y_acc+=S, y_cnt++;
  - last pixel (eof): go to IDLE, deassert coord_valid and busy.
- Flags: eol = (x_cnt==H_OUT-1); eof = eol && (y_cnt==V_OUT-1).
- Width rule: the accumulators are 26-bit unsigned; the maximum value is below H_OUT*2^16, so there is no overflow or saturation.
- frame_start while busy is ignored.
- zoom_level changes take effect only at the next accepted frame_start, so there is no mid-frame tearing.
- While coord_valid=1 and coord_ready=0, every output holds stable.

## Timing
- Reset values: lut_raddr=0, S=0x10000, coord_valid=0, busy=0, eol=0, eof=0, all coordinates 0; FSM in IDLE.
- frame_start at cycle 0: LATCH at 1, CALC at 2, coord_valid=1 at cycle 3 with the (0,0) coordinate; busy=1 from cycle 1.
- Throughput is one coordinate per cycle while coord_ready=1. A full frame with no stalls takes H_OUT*V_OUT+3 cycles from frame_start to IDLE.
- A frame_start in the same cycle as the final handshake is ignored (busy is still high).
- rst asserted mid-frame returns every output to its reset value on the next edge; nothing further is emitted until a new frame_start.

## Structure
- Package scale_pkg holds H_OUT/V_OUT defaults, the LUT max index (240), the unity step 0x10000, and the FSM state enum.
- Natural sub-module: scale_axis_acc, instantiated twice (x and y). It contains the offset multiply, the accumulator, the counter, and the clamp for *_next. The top level holds the FSM, the handshake and the LUT interface.

## Test plan
- zoom_level=0 -> S=0x10000; pixel n of line m gives sx_int=n, sy_int=m, frac=0; sx_next saturates at 639 on x=639.
- zoom_level=160 (LUT 0xC000) -> first coordinate sx=80.0, sy=60.0; second coordinate sx_int=80, sx_frac=0xC0; last in line sx_int=559, sx_frac=0x40; last line sy_int=419, sy_frac=0x40.
- zoom_level=240 (LUT 0xAAAA) -> eof asserted exactly on the 307200th handshake; no coordinate exceeds 639/479.
- coord_ready toggled randomly -> outputs stable while stalled; the coordinate sequence is identical to the no-stall run.
- zoom_level changed and frame_start pulsed mid-RUN -> current frame completes with the old S; busy stays high; the next frame_start uses the new ratio.
- rst pulsed mid-frame -> coord_valid=0 and lut_raddr=0 the next cycle; a later frame_start restarts at (0,0) with latency 3.

Source files
------------

// File: rtl/scale_pkg.sv
// Shared constants and FSM state type for the scaler coordinate generator.
package scale_pkg;
    localparam int H_OUT_DEF = 640;
    localparam int V_OUT_DEF = 480;
    localparam logic [9:0] LUT_MAX = 10'd240;
    localparam logic [16:0] UNITY = 17'h10000;

    typedef enum logic [1:0] {IDLE, LATCH, CALC, RUN} state_t;
endpackage

// File: rtl/scale_axis_acc.sv
// One axis of the source-coordinate walk: centring offset, 10.16 accumulator,
// output counter and clamped neighbour index.
module scale_axis_acc
    import scale_pkg::*;
#(
    parameter int N      = 640,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic              wrap,
    input  logic [16:0]       step,
    output logic [9:0]        coord_int,
    output logic [9:0]        coord_next,
    output logic [FRAC_W-1:0] coord_frac,
    output logic              last
);
    localparam logic [25:0] HALF    = 26'(N / 2);
    localparam logic [9:0]  MAX_IDX = 10'(N - 1);

    logic [25:0] acc;
    logic [25:0] off;
    logic [9:0]  cnt;

    // Centres the zoomed window: (N/2)*(1-S) in 10.16, never negative since S <= 1.0
    assign off = HALF * (26'(UNITY) - 26'(step));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (load || wrap) begin
            acc <= off;
            cnt <= '0;
        end else if (inc) begin
            acc <= acc + 26'(step);
            cnt <= cnt + 10'd1;
        end
    end

    assign coord_int  = acc[25:16];
    assign coord_frac = acc[15:16-FRAC_W];
    assign coord_next = (coord_int >= MAX_IDX) ? MAX_IDX : coord_int + 10'd1;
    assign last       = (cnt == MAX_IDX);
endmodule

// File: rtl/scale_coord_gen.sv
// Frame-walk controller: fetches the zoom step from the ratio LUT once per frame
// and streams centred source coordinates in raster order over valid/ready.
module scale_coord_gen
    import scale_pkg::*;
#(
    parameter int H_OUT  = H_OUT_DEF,
    parameter int V_OUT  = V_OUT_DEF,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        zoom_level,
    input  logic              frame_start,
    output logic [9:0]        lut_raddr,
    input  logic [15:0]       lut_data,
    output logic              busy,
    output logic              coord_valid,
    input  logic              coord_ready,
    output logic [9:0]        sx_int,
    output logic [9:0]        sy_int,
    output logic [9:0]        sx_next,
    output logic [9:0]        sy_next,
    output logic [FRAC_W-1:0] sx_frac,
    output logic [FRAC_W-1:0] sy_frac,
    output logic              eol,
    output logic              eof
);
    state_t state, state_nxt;
    logic [16:0] step;
    logic run, hs, x_last, y_last, load;
    logic [9:0] x_int, y_int, x_next, y_next;
    logic [FRAC_W-1:0] x_frac, y_frac;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lut_raddr <= '0;
            step      <= UNITY;
        end else begin
            state <= state_nxt;
            if (state == IDLE && frame_start)
                lut_raddr <= zoom_level;
            // Index 0 and out-of-range indices fall back to unity zoom
            if (state == LATCH)
                step <= (lut_raddr == '0 || lut_raddr > LUT_MAX) ? UNITY : {1'b0, lut_data};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (frame_start) state_nxt = LATCH;
            LATCH: state_nxt = CALC;
            CALC:  state_nxt = RUN;
            RUN:   if (hs && x_last && y_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign run  = (state == RUN);
    assign hs   = run && coord_ready;
    assign load = (state == CALC);

    scale_axis_acc #(.N(H_OUT), .FRAC_W(FRAC_W)) u_x (
        .clk(clk), .rst(rst), .load(load),
        .inc(hs && !x_last), .wrap(hs && x_last), .step(step),
        .coord_int(x_int), .coord_next(x_next), .coord_frac(x_frac), .last(x_last)
    );

    scale_axis_acc #(.N(V_OUT), .FRAC_W(FRAC_W)) u_y (
        .clk(clk), .rst(rst), .load(load),
        .inc(hs && x_last && !y_last), .wrap(1'b0), .step(step),
        .coord_int(y_int), .coord_next(y_next), .coord_frac(y_frac), .last(y_last)
    );

    // Coordinates read as zero whenever no coordinate is being offered
    assign coord_valid = run;
    assign busy        = (state != IDLE);
    assign sx_int      = run ? x_int  : '0;
    assign sy_int      = run ? y_int  : '0;
    assign sx_next     = run ? x_next : '0;
    assign sy_next     = run ? y_next : '0;
    assign sx_frac     = run ? x_frac : '0;
    assign sy_frac     = run ? y_frac : '0;
    assign eol         = run && x_last;
    assign eof         = run && x_last && y_last;
endmodule

// File: tb/tb_scale_coord_gen.sv
// Self-checking bench for scale_coord_gen on a reduced 64x48 frame.
module tb_scale_coord_gen;
    localparam int H = 64;
    localparam int V = 48;
    localparam int FW = 8;
    localparam int NPIX = H * V;

    logic clk, rst, frame_start, coord_ready, busy, coord_valid, eol, eof;
    logic [9:0] zoom_level, lut_raddr, sx_int, sy_int, sx_next, sy_next;
    logic [15:0] lut_data;
    logic [FW-1:0] sx_frac, sy_frac;
    logic [59:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    logic [59:0] cap [NPIX];
    logic [59:0] ref_cap [NPIX];

    typedef struct {
        int zoom; int n; int m;
        logic [9:0] sxi, sxn, syi, syn;
        logic [7:0] sxf, syf;
        logic e_eol, e_eof;
    } vec_t;
    vec_t tbl [13];

    scale_coord_gen #(.H_OUT(H), .V_OUT(V), .FRAC_W(FW)) dut (
        .clk(clk), .rst(rst), .zoom_level(zoom_level), .frame_start(frame_start),
        .lut_raddr(lut_raddr), .lut_data(lut_data), .busy(busy),
        .coord_valid(coord_valid), .coord_ready(coord_ready),
        .sx_int(sx_int), .sy_int(sy_int), .sx_next(sx_next), .sy_next(sy_next),
        .sx_frac(sx_frac), .sy_frac(sy_frac), .eol(eol), .eof(eof)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lut_model(input logic [9:0] a);
        if (a >= 10'd1 && a <= 10'd240)
            return 16'((480 * 65536) / (480 + int'(a)));
        return 16'h5A5A;
    endfunction

    always_comb lut_data = lut_model(lut_raddr);

    function automatic int step_of(input int k);
        if (k == 0 || k > 240) return 65536;
        return int'(lut_model(10'(k)));
    endfunction

    // Source position of output pixel n computed directly: centre offset + n*S
    function automatic logic [59:0] model_vec(input int s, input int n, input int m);
        longint px, py;
        int xi, yi, xf, yf, xn, yn;
        bit e1, e2;
        px = longint'(H / 2) * longint'(65536 - s) + longint'(n) * longint'(s);
        py = longint'(V / 2) * longint'(65536 - s) + longint'(m) * longint'(s);
        xi = int'(px >>> 16);
        yi = int'(py >>> 16);
        xf = int'((px >>> 8) & 255);
        yf = int'((py >>> 8) & 255);
        xn = (xi + 1 > H - 1) ? H - 1 : xi + 1;
        yn = (yi + 1 > V - 1) ? V - 1 : yi + 1;
        e1 = (n == H - 1);
        e2 = e1 && (m == V - 1);
        return {1'b1, 1'b1, 10'(xi), 10'(yi), 10'(xn), 10'(yn), 8'(xf), 8'(yf), e1, e2};
    endfunction

    assign obs = {coord_valid, busy, sx_int, sy_int, sx_next, sy_next, sx_frac, sy_frac, eol, eof};

    task automatic check_vec(input string name, input logic [59:0] got, input logic [59:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic run_frame(input int zoom, input int stall_pct, input int inj_idx,
                             input int new_zoom, input bit fs_end);
        int s, idx, cyc;
        bit inj_done;
        s = step_of(zoom);
        @(posedge clk); #1;
        zoom_level = 10'(zoom);
        frame_start = 1;
        coord_ready = 0;
        @(posedge clk); #1;
        frame_start = 0;
        @(negedge clk);
        check_val("latch_busy", int'(busy), 1);
        check_val("latch_valid", int'(coord_valid), 0);
        check_val("latch_raddr", int'(lut_raddr), zoom);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("calc_valid", int'(coord_valid), 0);
        @(posedge clk);
        idx = 0; cyc = 0; inj_done = 0;
        while (idx < NPIX && cyc < NPIX * 20 + 100) begin
            #1;
            coord_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            if (fs_end && idx == NPIX - 1) coord_ready = 1;
            frame_start = (!inj_done && idx == inj_idx) || (fs_end && idx == NPIX - 1);
            if (!inj_done && idx == inj_idx) begin
                zoom_level = 10'(new_zoom);
                inj_done = 1;
            end
            @(negedge clk);
            check_vec("coord", obs, model_vec(s, idx % H, idx / H));
            cap[idx] = obs;
            if (coord_ready && coord_valid) idx++;
            cyc++;
            @(posedge clk);
        end
        #1;
        frame_start = 0;
        coord_ready = 0;
        if (idx < NPIX) check_val("frame_timeout", idx, NPIX);
        if (stall_pct == 0) check_val("frame_cycles", cyc, NPIX);
        repeat (3) begin
            @(negedge clk);
            check_val("end_busy", int'(busy), 0);
            check_val("end_valid", int'(coord_valid), 0);
        end
    endtask

    task automatic check_table(input int z);
        foreach (tbl[i]) begin
            if (tbl[i].zoom == z)
                check_vec($sformatf("tbl%0d", i), cap[tbl[i].m * H + tbl[i].n],
                          {1'b1, 1'b1, tbl[i].sxi, tbl[i].syi, tbl[i].sxn, tbl[i].syn,
                           tbl[i].sxf, tbl[i].syf, tbl[i].e_eol, tbl[i].e_eof});
        end
    endtask

    initial begin
        int diffs, over;
        //           zoom  n   m  sxi sxn syi syn  sxf    syf  eol eof
        tbl[0]  = '{0,     0,  0,  0,  1,  0,  1, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0,    63,  0, 63, 63,  0,  1, 8'h00, 8'h00, 1, 0};
        tbl[2]  = '{0,     5,  7,  5,  6,  7,  8, 8'h00, 8'h00, 0, 0};
        tbl[3]  = '{0,    63, 47, 63, 63, 47, 47, 8'h00, 8'h00, 1, 1};
        tbl[4]  = '{160,   0,  0,  8,  9,  6,  7, 8'h00, 8'h00, 0, 0};
        tbl[5]  = '{160,   1,  0,  8,  9,  6,  7, 8'hC0, 8'h00, 0, 0};
        tbl[6]  = '{160,  63,  0, 55, 56,  6,  7, 8'h40, 8'h00, 1, 0};
        tbl[7]  = '{160,   0, 47,  8,  9, 41, 42, 8'h00, 8'h40, 0, 0};
        tbl[8]  = '{160,  63, 47, 55, 56, 41, 42, 8'h40, 8'h40, 1, 1};
        tbl[9]  = '{240,   0,  0, 10, 11,  8,  9, 8'hAA, 8'h00, 0, 0};
        tbl[10] = '{240,  63,  0, 52, 53,  8,  9, 8'hAA, 8'h00, 1, 0};
        tbl[11] = '{240,  62, 47, 51, 52, 39, 40, 8'hFF, 8'h55, 0, 0};
        tbl[12] = '{240,  63, 47, 52, 53, 39, 40, 8'hAA, 8'h55, 1, 1};

        rst = 1; zoom_level = 0; frame_start = 0; coord_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("reset_outputs", obs, 60'd0);
        check_val("reset_raddr", int'(lut_raddr), 0);
        @(posedge clk); #1;
        rst = 0;

        run_frame(0, 0, -1, 0, 0);
        check_table(0);

        run_frame(160, 0, -1, 0, 0);
        check_table(160);
        for (int i = 0; i < NPIX; i++) ref_cap[i] = cap[i];

        run_frame(160, 40, -1, 0, 0);
        diffs = 0;
        for (int i = 0; i < NPIX; i++) if (cap[i] !== ref_cap[i]) diffs++;
        check_val("stall_seq_diff", diffs, 0);

        run_frame(240, 0, -1, 0, 0);
        check_table(240);
        over = 0;
        for (int i = 0; i < NPIX; i++)
            if (cap[i][57:48] > 10'(H - 1) || cap[i][47:38] > 10'(V - 1)) over++;
        check_val("coord_range", over, 0);

        // New zoom + frame_start mid-frame: frame finishes at ratio 160, next uses 240
        run_frame(160, 20, 100, 240, 0);
        run_frame(240, 10, -1, 0, 0);

        // Out-of-range index behaves as unity; frame_start on the final handshake is dropped
        run_frame(500, 0, -1, 0, 1);

        @(posedge clk); #1;
        zoom_level = 10'd160;
        frame_start = 1;
        @(posedge clk); #1;
        frame_start = 0;
        coord_ready = 1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check_val("pre_rst_valid", int'(coord_valid), 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check_vec("mid_rst_outputs", obs, 60'd0);
        check_val("mid_rst_raddr", int'(lut_raddr), 0);
        repeat (4) begin
            @(negedge clk);
            check_val("post_rst_idle", int'(coord_valid), 0);
        end
        coord_ready = 0;
        run_frame(0, 15, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
